// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared op codes, state encoding and op-class helpers for md_unit
package md_unit_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9,
    OP_NONE  = 4'd15
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Multiply-class ops all share the MULT_CYCLES latency
  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - issue/result bundle between the Execute stage and md_unit
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (output start, op, a, b, input busy, hi, lo, dz);
  modport slave  (input start, op, a, b, output busy, hi, lo, dz);
endinterface

// File: rtl/md_unit_calc.sv
// rtl/md_unit_calc.sv - combinational multiply/accumulate/divide result generator
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz_next
);
  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]           acc;
  logic [W2-1:0]           res;
  logic signed [W2-1:0]    sa;
  logic signed [W2-1:0]    sb;
  logic [W2-1:0]           sprod;
  logic [W2-1:0]           uprod;
  logic [WIDTH-1:0]        dvs;
  logic signed [WIDTH-1:0] sq;
  logic signed [WIDTH-1:0] sr;
  logic [WIDTH-1:0]        uq;
  logic [WIDTH-1:0]        ur;
  logic                    min_neg1;

  // Products, quotients and the op-selected {hi,lo} result; a zero divisor is
  // replaced by 1 so the dividers never see it, the result is then discarded
  always_comb begin
    acc      = {hi, lo};
    sa       = {{WIDTH{a[WIDTH-1]}}, a};
    sb       = {{WIDTH{b[WIDTH-1]}}, b};
    sprod    = sa * sb;
    uprod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    dvs      = (b == '0) ? WIDTH'(1) : b;
    sq       = $signed(a) / $signed(dvs);
    sr       = $signed(a) % $signed(dvs);
    uq       = a / dvs;
    ur       = a % dvs;
    min_neg1 = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    res      = acc;
    dz_next  = 1'b0;
    case (op)
      OP_MULT:  res = sprod;
      OP_MULTU: res = uprod;
      OP_MADD:  res = acc + sprod;
      OP_MADDU: res = acc + uprod;
      OP_MSUB:  res = acc - sprod;
      OP_MSUBU: res = acc - uprod;
      OP_DIV: begin
        if (b == '0)    dz_next = 1'b1;
        else if (min_neg1) res = {{WIDTH{1'b0}}, a};
        else            res = {sr, sq};
      end
      OP_DIVU: begin
        if (b == '0) dz_next = 1'b1;
        else         res = {ur, uq};
      end
      default: res = acc;
    endcase
    res_hi = res[W2-1:WIDTH];
    res_lo = res[WIDTH-1:0];
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with private HI/LO registers
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  md_unit_if.slave   md
);
  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_e        state;
  md_state_e        state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;
  logic             res_dz_q;
  logic             dz_q;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             calc_dz;
  logic             launch;
  logic             finish;
  logic             write_hi;
  logic             write_lo;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op      (md.op),
    .a       (md.a),
    .b       (md.b),
    .hi      (hi_q),
    .lo      (lo_q),
    .res_hi  (calc_hi),
    .res_lo  (calc_lo),
    .dz_next (calc_dz)
  );

  // Next state and per-cycle control: starts are only honoured in IDLE
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    finish     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (md.start) begin
          if (is_mult_op(md.op) || is_div_op(md.op)) begin
            launch     = 1'b1;
            state_next = ST_RUN;
          end
          write_hi = (md.op == OP_MTHI);
          write_lo = (md.op == OP_MTLO);
        end
      end
      ST_RUN: begin
        if (cnt == CW'(1)) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Result capture at launch, countdown, and HI/LO/dz commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_dz_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      if (launch) begin
        res_hi_q <= calc_hi;
        res_lo_q <= calc_lo;
        res_dz_q <= calc_dz;
        dz_q     <= 1'b0;
        cnt      <= is_div_op(md.op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == ST_RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (finish) begin
        hi_q <= res_hi_q;
        lo_q <= res_lo_q;
        dz_q <= res_dz_q;
      end
      if (write_hi) begin
        hi_q <= md.a;
        dz_q <= 1'b0;
      end
      if (write_lo) begin
        lo_q <= md.a;
        dz_q <= 1'b0;
      end
    end
  end

  assign md.busy = (state == ST_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign md.dz   = dz_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit with a reference model and randomized ops
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) m32 ();
  md_unit_if #(.WIDTH(16)) m16 ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut32 (
    .clk   (clk),
    .reset (rst_n),
    .md    (m32.slave)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
    .clk   (clk),
    .reset (rst_n),
    .md    (m16.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec arithmetic on 64-bit values, pushes what the DUT must show
  task automatic model_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, q, r;
    logic [63:0] prod_s, prod_u, acc;
    exp_t e;
    sa     = {{32{a[31]}}, a};
    sbv    = {{32{b[31]}}, b};
    prod_s = sa * sbv;
    prod_u = {32'b0, a} * {32'b0, b};
    acc    = {m_hi, m_lo};
    e.dz     = 1'b0;
    e.cycles = MC;
    case (op)
      4'd0: acc = prod_s;
      4'd1: acc = prod_u;
      4'd6: acc = acc + prod_s;
      4'd7: acc = acc + prod_u;
      4'd8: acc = acc - prod_s;
      4'd9: acc = acc - prod_u;
      4'd2: begin
        e.cycles = DC;
        if (b == 0) e.dz = 1'b1;
        else begin
          q   = sa / sbv;
          r   = sa % sbv;
          acc = {r[31:0], q[31:0]};
        end
      end
      4'd3: begin
        e.cycles = DC;
        if (b == 0) e.dz = 1'b1;
        else acc = {a % b, a / b};
      end
      4'd4: begin acc[63:32] = a; e.cycles = 0; end
      4'd5: begin acc[31:0]  = a; e.cycles = 0; end
      default: return;
    endcase
    m_hi = acc[63:32];
    m_lo = acc[31:0];
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
  endtask

  // Honour the stall contract, then present one start cycle
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (m32.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 64'(m32.busy), 64'(0));
    model_issue(op, a, b);
    m32.start = 1'b1;
    m32.op    = op;
    m32.a     = a;
    m32.b     = b;
    @(negedge clk);
    m32.start = 1'b0;
    m32.op    = 4'd15;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: an MT write or a busy fall is an output event; pop and compare
  initial begin
    logic       prev_busy = 1'b0;
    int         bcnt = 0;
    logic       st;
    logic [3:0] o;
    exp_t       e;
    forever begin
      @(posedge clk);
      st = m32.start;
      o  = m32.op;
      #1;
      if (!rst_n) begin
        prev_busy = 1'b0;
        bcnt      = 0;
      end else begin
        if ((!prev_busy && st && (o == 4'd4 || o == 4'd5)) || (prev_busy && !m32.busy)) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("hi", 64'(m32.hi), 64'(e.hi));
            chk("lo", 64'(m32.lo), 64'(e.lo));
            chk("dz", 64'(m32.dz), 64'(e.dz));
            chk("busy_cycles", 64'(bcnt), 64'(e.cycles));
          end
          bcnt = 0;
        end
        if (m32.busy) bcnt++;
        prev_busy = m32.busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m32.start = 1'b0; m32.op = 4'd15; m32.a = '0; m32.b = '0;
    m16.start = 1'b0; m16.op = 4'd15; m16.a = '0; m16.b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_hi", 64'(m32.hi), 64'(0));
    chk("rst_lo", 64'(m32.lo), 64'(0));
    chk("rst_busy", 64'(m32.busy), 64'(0));
    chk("rst_dz", 64'(m32.dz), 64'(0));

    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7);
    issue(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(OP_DIVU,  32'd7, 32'd0);
    issue(OP_MULT,  32'd2, 32'd3);
    chk("dz_cleared_on_start", 64'(m32.dz), 64'(0));
    issue(OP_MTHI,  32'h1234_5678, 32'd0);
    issue(OP_MTLO,  32'h9ABC_DEF0, 32'd0);
    issue(OP_MADDU, 32'd1, 32'd1);
    issue(OP_MTHI,  32'd0, 32'd0);
    issue(OP_MTLO,  32'd0, 32'd0);
    issue(OP_MSUB,  32'd1, 32'd1);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

    // Reset during RUN cycle 3 of a DIV: async clear, pending result dropped
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(m32.busy), 64'(0));
    chk("async_rst_hi", 64'(m32.hi), 64'(0));
    chk("async_rst_lo", 64'(m32.lo), 64'(0));
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(m32.busy), 64'(0));
    chk("post_rst_hi", 64'(m32.hi), 64'(0));
    chk("post_rst_lo", 64'(m32.lo), 64'(0));

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 9));
      issue(op, pick(), pick());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));

    // 16-bit, single-cycle build: a start during the one busy cycle is ignored
    m16.start = 1'b1; m16.op = OP_MULTU; m16.a = 16'hFFFF; m16.b = 16'hFFFF;
    @(negedge clk);
    chk("w16_busy", 64'(m16.busy), 64'(1));
    m16.op = OP_MTHI; m16.a = 16'h5555;
    @(negedge clk);
    m16.start = 1'b0; m16.op = 4'd15;
    chk("w16_busy_drop", 64'(m16.busy), 64'(0));
    chk("w16_hi", 64'(m16.hi), 64'(16'hFFFE));
    chk("w16_lo", 64'(m16.lo), 64'(16'h0001));
    @(negedge clk);
    chk("w16_hi_hold", 64'(m16.hi), 64'(16'hFFFE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
